// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S receive frame controller.
package i2s_rx_pkg;

   localparam int unsigned I2S_DATA_W = 24;

   localparam logic LR_LEFT  = 1'b0;
   localparam logic LR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_L = 2'd1,
      WAIT_R = 2'd2
   } i2s_rx_state_e;

endpackage

// File: rtl/i2s_word_event.sv
// Rising-edge detector on the receiver valid level; splits the word into channel flag and sample.
module i2s_word_event
   import i2s_rx_pkg::*;
#(
   parameter int unsigned DATA_W = I2S_DATA_W
) (
   input  logic              bclk,
   input  logic              rst,
   input  logic              rx_valid_i,
   input  logic [DATA_W:0]   rx_data_i,
   output logic              evt_o,
   output logic              lr_o,
   output logic [DATA_W-1:0] sample_o
);

   logic valid_prev_q;

   always_ff @(posedge bclk) begin
      if (!rst) begin
         valid_prev_q <= 1'b0;
      end else begin
         valid_prev_q <= rx_valid_i;
      end
   end

   // Data is taken in the same cycle as the strobe, no extra register stage.
   assign evt_o    = rx_valid_i & ~valid_prev_q;
   assign lr_o     = rx_data_i[DATA_W];
   assign sample_o = rx_data_i[DATA_W-1:0];

endmodule

// File: rtl/i2s_rx_frame_ctrl.sv
// Pairs left/right I2S words into stereo frames with a valid/ready output handshake.
// Optional macro I2S_RX_OVERRUN_CNT_EN enables the saturating dropped-frame counter.
//
// state  | meaning
// IDLE   | capture disabled, word events ignored
// WAIT_L | waiting for a left word, right words discarded
// WAIT_R | left sample held, waiting for its right partner
module i2s_rx_frame_ctrl
   import i2s_rx_pkg::*;
#(
   parameter int unsigned DATA_W = I2S_DATA_W
) (
   input  logic              bclk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DATA_W:0]   rx_data,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] frame_left,
   output logic [DATA_W-1:0] frame_right,
   output logic              frame_valid,
   input  logic              frame_ready,
   output logic              busy,
   output logic              sync_err,
   output logic              overrun,
   output logic [15:0]       overrun_count
);

   logic              evt;
   logic              evt_lr;
   logic [DATA_W-1:0] evt_sample;

   i2s_rx_state_e     state_q,   state_d;
   logic [DATA_W-1:0] hold_q,    hold_d;
   logic [DATA_W-1:0] left_q,    left_d;
   logic [DATA_W-1:0] right_q,   right_d;
   logic              fvalid_q,  fvalid_d;
   logic              sync_q,    sync_d;
   logic              ovr_q,     ovr_d;
   logic              complete;
   logic              accept;

   i2s_word_event #(
      .DATA_W (DATA_W)
   ) u_word_event (
      .bclk       (bclk),
      .rst        (rst),
      .rx_valid_i (rx_valid),
      .rx_data_i  (rx_data),
      .evt_o      (evt),
      .lr_o       (evt_lr),
      .sample_o   (evt_sample)
   );

   always_ff @(posedge bclk) begin
      if (!rst) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         left_q   <= '0;
         right_q  <= '0;
         fvalid_q <= 1'b0;
         sync_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         left_q   <= left_d;
         right_q  <= right_d;
         fvalid_q <= fvalid_d;
         sync_q   <= sync_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      left_d   = left_q;
      right_d  = right_q;
      fvalid_d = fvalid_q;
      sync_d   = 1'b0;
      ovr_d    = 1'b0;
      complete = 1'b0;
      accept   = fvalid_q & frame_ready;

      // enable low wins over a word event in the same cycle
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = WAIT_L;
            end
         end
         WAIT_L: begin
            if (!enable) begin
               state_d = IDLE;
               hold_d  = '0;
            end else if (evt && (evt_lr == LR_LEFT)) begin
               hold_d  = evt_sample;
               state_d = WAIT_R;
            end
         end
         WAIT_R: begin
            if (!enable) begin
               state_d = IDLE;
               hold_d  = '0;
            end else if (evt) begin
               if (evt_lr == LR_RIGHT) begin
                  complete = 1'b1;
                  state_d  = WAIT_L;
               end else begin
                  hold_d = evt_sample;
                  sync_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase

      // An accept in the completion cycle frees the slot for the new frame.
      if (complete) begin
         if (!fvalid_q || accept) begin
            fvalid_d = 1'b1;
            left_d   = hold_q;
            right_d  = evt_sample;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (accept) begin
         fvalid_d = 1'b0;
      end
   end

`ifdef I2S_RX_OVERRUN_CNT_EN
   logic [15:0] ovr_cnt_q, ovr_cnt_d;

   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (ovr_d && (ovr_cnt_q != 16'hFFFF)) begin
         ovr_cnt_d = ovr_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge bclk) begin
      if (!rst) begin
         ovr_cnt_q <= '0;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_count = ovr_cnt_q;
`else
   assign overrun_count = 16'd0;
`endif

   assign frame_left  = left_q;
   assign frame_right = right_q;
   assign frame_valid = fvalid_q;
   assign busy        = (state_q != IDLE);
   assign sync_err    = sync_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// Directed bench for i2s_rx_frame_ctrl: per-cycle vector table plus handshake/reset sequences.
module tb_i2s_rx_frame_ctrl;

   localparam int DW = 24;
`ifdef I2S_RX_OVERRUN_CNT_EN
   localparam int EXP_OVR_CNT = 2;
`else
   localparam int EXP_OVR_CNT = 0;
`endif

   logic          bclk;
   logic          rst;
   logic          enable;
   logic [DW:0]   rx_data;
   logic          rx_valid;
   logic [DW-1:0] frame_left;
   logic [DW-1:0] frame_right;
   logic          frame_valid;
   logic          frame_ready;
   logic          busy;
   logic          sync_err;
   logic          overrun;
   logic [15:0]   overrun_count;

   int n_chk  = 0;
   int n_pass = 0;
   int ovr_seen  = 0;
   int sync_seen = 0;

   i2s_rx_frame_ctrl dut (
      .bclk          (bclk),
      .rst           (rst),
      .enable        (enable),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .frame_left    (frame_left),
      .frame_right   (frame_right),
      .frame_valid   (frame_valid),
      .frame_ready   (frame_ready),
      .busy          (busy),
      .sync_err      (sync_err),
      .overrun       (overrun),
      .overrun_count (overrun_count)
   );

   initial bclk = 1'b0;
   always #5 bclk = ~bclk;

   typedef struct {
      logic          rst_n;
      logic          en;
      logic          v;
      logic          lr;
      logic [DW-1:0] s;
      logic          rdy;
      logic          fv;
      logic [DW-1:0] fl;
      logic [DW-1:0] fr;
      logic          bsy;
      logic          se;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge bclk);
      #1;
      if (overrun)  ovr_seen++;
      if (sync_err) sync_seen++;
   endtask

   task automatic do_reset();
      rst = 1'b0; enable = 1'b0; rx_valid = 1'b0; rx_data = '0; frame_ready = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // one low cycle, then the rising valid cycle; outputs are sampled after the event edge
   task automatic word(input logic lr, input logic [DW-1:0] s, input logic rdy);
      rx_valid = 1'b0; frame_ready = 1'b0;
      tick();
      rx_valid = 1'b1; rx_data = {lr, s}; frame_ready = rdy;
      tick();
      rx_valid = 1'b0; frame_ready = 1'b0;
   endtask

   initial begin
      //           rst en v  lr  sample       rdy  fv fl         fr         busy se
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     1'b1,1'b0};
      tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,24'h123456,1'b0, 1'b0,24'h0,     24'h0,     1'b1,1'b0};
      tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     1'b1,1'b0};
      tbl[4]  = '{1'b1,1'b1,1'b1,1'b1,24'hABCDEF,1'b1, 1'b1,24'h123456,24'hABCDEF,1'b1,1'b0};
      tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,24'h0,     1'b1, 1'b0,24'h123456,24'hABCDEF,1'b1,1'b0};
      tbl[6]  = '{1'b1,1'b1,1'b1,1'b1,24'h1,     1'b0, 1'b0,24'h123456,24'hABCDEF,1'b1,1'b0};
      tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,24'h0,     1'b0, 1'b0,24'h123456,24'hABCDEF,1'b1,1'b0};
      tbl[8]  = '{1'b1,1'b1,1'b1,1'b0,24'h11,    1'b0, 1'b0,24'h123456,24'hABCDEF,1'b1,1'b0};
      tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,24'h0,     1'b0, 1'b0,24'h123456,24'hABCDEF,1'b1,1'b0};
      tbl[10] = '{1'b1,1'b1,1'b1,1'b1,24'h22,    1'b0, 1'b1,24'h11,    24'h22,    1'b1,1'b0};
      tbl[11] = '{1'b1,1'b1,1'b0,1'b0,24'h0,     1'b0, 1'b1,24'h11,    24'h22,    1'b1,1'b0};
      tbl[12] = '{1'b1,1'b1,1'b0,1'b0,24'h0,     1'b1, 1'b0,24'h11,    24'h22,    1'b1,1'b0};
      tbl[13] = '{1'b1,1'b1,1'b1,1'b0,24'h1,     1'b0, 1'b0,24'h11,    24'h22,    1'b1,1'b0};
      tbl[14] = '{1'b1,1'b1,1'b0,1'b0,24'h0,     1'b0, 1'b0,24'h11,    24'h22,    1'b1,1'b0};
      tbl[15] = '{1'b1,1'b1,1'b1,1'b0,24'h2,     1'b0, 1'b0,24'h11,    24'h22,    1'b1,1'b1};
      tbl[16] = '{1'b1,1'b1,1'b0,1'b0,24'h0,     1'b0, 1'b0,24'h11,    24'h22,    1'b1,1'b0};
      tbl[17] = '{1'b1,1'b1,1'b1,1'b1,24'h3,     1'b1, 1'b1,24'h2,     24'h3,     1'b1,1'b0};
      tbl[18] = '{1'b1,1'b1,1'b0,1'b0,24'h0,     1'b1, 1'b0,24'h2,     24'h3,     1'b1,1'b0};

      rst = 1'b0; enable = 1'b0; rx_valid = 1'b0; rx_data = '0; frame_ready = 1'b0;
      #2;

      for (int i = 0; i < 19; i++) begin
         rst = tbl[i].rst_n; enable = tbl[i].en; rx_valid = tbl[i].v;
         rx_data = {tbl[i].lr, tbl[i].s}; frame_ready = tbl[i].rdy;
         tick();
         check($sformatf("vec%0d frame_valid", i), 32'(frame_valid), 32'(tbl[i].fv));
         check($sformatf("vec%0d frame_left", i),  32'(frame_left),  32'(tbl[i].fl));
         check($sformatf("vec%0d frame_right", i), 32'(frame_right), 32'(tbl[i].fr));
         check($sformatf("vec%0d busy", i),        32'(busy),        32'(tbl[i].bsy));
         check($sformatf("vec%0d sync_err", i),    32'(sync_err),    32'(tbl[i].se));
         check($sformatf("vec%0d overrun", i),     32'(overrun),     32'd0);
      end
      check("table sync_err pulses", 32'(sync_seen), 32'd1);

      // three frames with the consumer stalled
      do_reset();
      enable = 1'b1; tick();
      ovr_seen = 0;
      word(1'b0, 24'hA1, 1'b0); word(1'b1, 24'hB1, 1'b0);
      check("stall first frame valid", 32'(frame_valid), 32'd1);
      word(1'b0, 24'hA2, 1'b0); word(1'b1, 24'hB2, 1'b0);
      check("stall second overrun pulse", 32'(overrun), 32'd1);
      word(1'b0, 24'hA3, 1'b0); word(1'b1, 24'hB3, 1'b0);
      tick();
      check("stall overrun pulses", 32'(ovr_seen), 32'd2);
      check("stall held left", 32'(frame_left), 32'h0000A1);
      check("stall held right", 32'(frame_right), 32'h0000B1);
      check("stall overrun_count", 32'(overrun_count), 32'(EXP_OVR_CNT));
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      check("stall accept drops valid", 32'(frame_valid), 32'd0);

      // accept coincides with a completion
      do_reset();
      enable = 1'b1; tick();
      ovr_seen = 0;
      word(1'b0, 24'hC1, 1'b0); word(1'b1, 24'hD1, 1'b0);
      word(1'b0, 24'hC2, 1'b0); word(1'b1, 24'hD2, 1'b1);
      check("coincide valid", 32'(frame_valid), 32'd1);
      check("coincide left", 32'(frame_left), 32'h0000C2);
      check("coincide right", 32'(frame_right), 32'h0000D2);
      check("coincide no overrun", 32'(ovr_seen), 32'd0);
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      check("coincide accept", 32'(frame_valid), 32'd0);

      // reset in WAIT_R with a frame pending
      do_reset();
      enable = 1'b1; tick();
      word(1'b0, 24'hE1, 1'b0); word(1'b1, 24'hE2, 1'b0);
      word(1'b0, 24'hE3, 1'b0);
      check("pre-reset pending", 32'(frame_valid), 32'd1);
      rst = 1'b0; tick();
      check("reset valid", 32'(frame_valid), 32'd0);
      check("reset left", 32'(frame_left), 32'd0);
      check("reset right", 32'(frame_right), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset pulses", 32'({sync_err, overrun}), 32'd0);
      check("reset count", 32'(overrun_count), 32'd0);
      rst = 1'b1;

      // disable with a left held, then restart from a fresh left
      enable = 1'b1; tick();
      word(1'b0, 24'h5, 1'b0);
      enable = 1'b0; tick();
      check("disable to idle", 32'(busy), 32'd0);
      enable = 1'b1; tick();
      word(1'b1, 24'h6, 1'b0);
      check("stale left not paired", 32'(frame_valid), 32'd0);
      word(1'b0, 24'h7, 1'b0); word(1'b1, 24'h8, 1'b0);
      check("fresh frame left", 32'(frame_left), 32'h7);
      check("fresh frame right", 32'(frame_right), 32'h8);

      // right word arriving as enable falls is ignored
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      word(1'b0, 24'h9, 1'b0);
      rx_valid = 1'b0; tick();
      rx_valid = 1'b1; rx_data = {1'b1, 24'hA}; enable = 1'b0;
      tick();
      rx_valid = 1'b0;
      check("enable-fall word ignored", 32'(frame_valid), 32'd0);
      check("enable-fall idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/i2s_rx_frame_ctrl.md
I2S_RX_FRAME_CTRL -- requirements
Module: i2s_rx_frame_ctrl

Interface
REQ-001 Parameter DATA_W, default 24: width of one audio sample word.
REQ-002 bclk  in  1  bit clock; all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 enable  in  1  capture enable, level.
REQ-005 rx_data  in  DATA_W+1  receiver word; bit DATA_W is the channel flag (0 = left, 1 = right); bits DATA_W-1:0 are the sample.
REQ-006 rx_valid  in  1  receiver valid level; the 0->1 transition marks one completed word.
REQ-007 frame_left  out  DATA_W  left sample of the presented frame.
REQ-008 frame_right  out  DATA_W  right sample of the presented frame.
REQ-009 frame_valid  out  1  stereo frame presented.
REQ-010 frame_ready  in  1  consumer accepts the frame.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 sync_err  out  1  one-cycle pulse when a left word replaces an unpaired left word.
REQ-013 overrun  out  1  one-cycle pulse when a completed frame is dropped.
REQ-014 overrun_count  out  16  saturating count of dropped frames.

Function
REQ-015 A word event SHALL fire in the cycle where rx_valid=1 and its registered previous value is 0; rx_data is sampled in that same cycle.
REQ-016 The state machine SHALL have states IDLE, WAIT_L and WAIT_R.
REQ-017 IDLE: enable=1 -> WAIT_L; word events are ignored.
REQ-018 WAIT_L: a left word is latched into the left holding register -> WAIT_R; right words are discarded silently.
REQ-019 WAIT_R: a right word completes a frame -> WAIT_L.
REQ-020 WAIT_R: a left word overwrites the held left sample, pulses sync_err, and the state stays WAIT_R.
REQ-021 Frame completion latency: frame_valid, frame_left and frame_right update on the first rising edge after the completing word event.
REQ-022 frame_valid and its data SHALL hold stable until a cycle with frame_valid=1 and frame_ready=1; frame_valid then drops on the next edge unless a new frame loads.
REQ-023 Completion with frame_valid=1 and frame_ready=0: the new frame is dropped, the presented frame is kept, and overrun pulses.
REQ-024 Completion in the same cycle as an accept: the new frame loads, frame_valid stays 1, and there is no overrun.
REQ-025 enable=0 in WAIT_L or WAIT_R: go to IDLE next edge and discard any held left sample; a presented frame stays until accepted.
REQ-026 A word event in the same cycle as enable falling is ignored.

Reset
REQ-027 rst=0 at a bclk edge SHALL force state IDLE and clear to 0: frame_valid, frame_left, frame_right, sync_err, overrun, overrun_count, the holding register and the previous-valid register.
REQ-028 Reset mid-frame or mid-handshake SHALL drop all data with no pulses.
REQ-029 rst has priority over all other inputs.

Configuration
REQ-030 Macro I2S_RX_OVERRUN_CNT_EN defined: overrun_count increments by 1 on each overrun pulse and saturates at 16'hFFFF.
REQ-031 Macro I2S_RX_OVERRUN_CNT_EN undefined: overrun_count is constant 0 and the counter logic is absent; the port list is unchanged.

Structure
REQ-032 Shared package i2s_rx_pkg SHALL hold the state enum typedef, the DATA_W default, and constants LR_LEFT=0 and LR_RIGHT=1.
REQ-033 Sub-module i2s_word_event SHALL implement the rx_valid registered edge detector and data capture strobe.
REQ-034 All remaining logic is contained in i2s_rx_frame_ctrl.

Verification
REQ-035 Reset release, enable=1, words L=0x123456 then R=0xABCDEF, ready=1 -> one frame_valid cycle, left=0x123456, right=0xABCDEF, exactly one edge after the R event.
REQ-036 Enable with R=0x000001 first, then L=0x11, R=0x22 -> first R discarded; frame left=0x11, right=0x22.
REQ-037 Sequence L=0x1, L=0x2, R=0x3 -> one sync_err pulse; frame left=0x2, right=0x3.
REQ-038 ready=0 while three frames complete -> first frame held, 2 overrun pulses; overrun_count=2 with macro, 0 without; then ready=1 -> first frame accepted.
REQ-039 frame_ready=1 in the exact cycle a second frame completes -> frame_valid stays 1, data becomes the second frame, no overrun.
REQ-040 rst=0 while in WAIT_R with a frame pending -> next edge: IDLE, all outputs 0; enable=0 with L held -> IDLE, next frame starts from a fresh L.
